ifu_fetch: RTL

Instruction fetch unit: owns the architectural PC, issues one instruction-memory read at a time, and presents the fetched instruction to ID. It is the consumer of EX's branch_flag/pc_new redirect. A redirect discards any wrong-path request or instruction, and fetch restarts at the new target.

---
 rtl/ifu_fetch_pkg.sv | 20 ++
 rtl/ifu_fetch_reg.sv | 21 ++
 rtl/ifu_fetch.sv | 110 +++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_fetch_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned INST_W = 32;

  localparam logic [ADDR_W-1:0] PC_START = 64'h0000_0000_8000_0000;
  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_REQ  = 2'd0,
    IF_WAIT = 2'd1,
    IF_OUT  = 2'd2
  } if_state_e;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_reg.sv
// rtl/ifu_fetch_reg.sv - write-enabled register with synchronous active-high reset
module ifu_fetch_reg #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - PC owner, single-outstanding imem fetch, redirect handling
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = PC_START
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_flag_i,
  input  logic [63:0] pc_new_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [63:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [63:0] pc_o,
  input  logic        id_ready_i
);

  if_state_e   state, state_d;
  logic [63:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [63:0] addr_hold_q;
  logic        hold_wen;
  logic [31:0] inst_q;
  logic [63:0] pc_out_q;
  logic        capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IF_REQ;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    pc_d    = pc_q;
    kill_d  = kill_q;
    capture = 1'b0;
    unique case (state)
      IF_REQ: begin
        if (imem_req_ready_i) state_d = IF_WAIT;
        if (branch_flag_i) begin
          pc_d   = align_pc(pc_new_i);
          kill_d = 1'b1;
        end
      end
      IF_WAIT: begin
        if (branch_flag_i) begin
          pc_d = align_pc(pc_new_i);
          if (imem_rsp_valid_i) begin
            state_d = IF_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rsp_valid_i) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = IF_REQ;
          end else begin
            capture = 1'b1;
            state_d = IF_OUT;
          end
        end
      end
      IF_OUT: begin
        if (branch_flag_i) begin
          pc_d    = align_pc(pc_new_i);
          state_d = IF_REQ;
        end else if (id_ready_i) begin
          pc_d    = pc_q + 64'd4;
          state_d = IF_REQ;
        end
      end
      default: state_d = IF_REQ;
    endcase
  end

  // A redirect in REQ before acceptance must not disturb the pending address,
  // so the request address is latched while the request is still right-path.
  assign hold_wen = (state == IF_REQ) && !kill_q;

  ifu_fetch_reg #(.WIDTH(64), .RESET_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .din(pc_d), .dout(pc_q), .wen(1'b1)
  );
  ifu_fetch_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_kill (
    .clk(clk), .rst(rst), .din(kill_d), .dout(kill_q), .wen(1'b1)
  );
  ifu_fetch_reg #(.WIDTH(64), .RESET_VAL(RESET_PC)) u_addr_hold (
    .clk(clk), .rst(rst), .din(pc_q), .dout(addr_hold_q), .wen(hold_wen)
  );
  ifu_fetch_reg #(.WIDTH(32), .RESET_VAL(INST_NOP)) u_inst (
    .clk(clk), .rst(rst), .din(imem_rsp_data_i), .dout(inst_q), .wen(capture)
  );
  ifu_fetch_reg #(.WIDTH(64), .RESET_VAL(64'd0)) u_pc_out (
    .clk(clk), .rst(rst), .din(pc_q), .dout(pc_out_q), .wen(capture)
  );

  assign imem_req_valid_o = (state == IF_REQ);
  assign imem_addr_o      = (state == IF_REQ && kill_q) ? addr_hold_q : pc_q;
  assign inst_valid_o     = (state == IF_OUT);
  assign inst_o           = inst_valid_o ? inst_q : INST_NOP;
  assign pc_o             = pc_out_q;

endmodule
